// File: rtl/rx_frame_len_check.sv
// rx_frame_len_check: measures RX frame byte length from the 64-bit aligned
// word stream and checks it against min/max bounds and the length/type field.
// Produces one registered status report per frame plus an abort pulse.
module rx_frame_len_check #(
  parameter int CNT_WIDTH = 11,
  parameter int MIN_LEN   = 64,
  parameter int MAX_LEN   = 1518
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic        rx_sof,
  input  logic        rx_eof,
  input  logic [2:0]  rx_eof_bytes,
  input  logic [63:0] rx_data,
  output logic        len_valid,
  output logic [15:0] frame_len,
  output logic        too_short,
  output logic        too_long,
  output logic        len_mismatch,
  output logic        frame_good,
  output logic        abort
);

  typedef enum logic {IDLE, IN_FRAME} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [16:0] MIN17 = 17'(MIN_LEN);
  localparam logic [16:0] MAX17 = 17'(MAX_LEN);

  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 ovf;
  logic [15:0]          len_field;

  logic [CNT_WIDTH-1:0] cnt_inc;
  logic [15:0]          cap_field;
  logic [CNT_WIDTH-1:0] rep_words;
  logic [15:0]          rep_lf;
  logic                 rep_sat;
  logic [3:0]           rep_bytes;
  logic [31:0]          len_wide;
  logic [15:0]          rep_len;
  logic                 rep_short;
  logic                 rep_long;
  logic                 rep_mism;

  // Report values for a frame ending on the current word. A frame ending on
  // its second word takes its length field straight from rx_data, since the
  // capture register only updates on that same edge.
  always_comb begin
    cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
    cap_field = {rx_data[39:32], rx_data[47:40]};
    if (rx_sof) begin
      rep_words = CNT_ONE;
      rep_lf    = '0;
      rep_sat   = 1'b0;
    end else begin
      rep_words = cnt_inc;
      rep_lf    = (cnt == CNT_ONE) ? cap_field : len_field;
      rep_sat   = ovf | (cnt_inc == CNT_MAX);
    end
    rep_bytes = (rx_eof_bytes == 3'd0) ? 4'd8 : {1'b0, rx_eof_bytes};
    len_wide  = ((32'(rep_words) - 32'd1) << 3) + 32'(rep_bytes);
    rep_len   = (|len_wide[31:16]) ? 16'hFFFF : len_wide[15:0];
    rep_short = ({1'b0, rep_len} < MIN17);
    rep_long  = ({1'b0, rep_len} > MAX17) | rep_sat;
    rep_mism  = 1'b0;
    if (rep_lf <= 16'd1500) begin
      if (rep_lf < 16'd46) rep_mism = (rep_len != 16'd64);
      else                 rep_mism = ({1'b0, rep_len} != ({1'b0, rep_lf} + 17'd18));
    end
  end

  // Frame FSM, word counter, length-field capture and registered report.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= CNT_ONE;
      ovf          <= 1'b0;
      len_field    <= '0;
      len_valid    <= 1'b0;
      frame_len    <= '0;
      too_short    <= 1'b0;
      too_long     <= 1'b0;
      len_mismatch <= 1'b0;
      frame_good   <= 1'b0;
      abort        <= 1'b0;
    end else begin
      len_valid <= 1'b0;
      abort     <= 1'b0;
      if (rx_valid && (rx_sof || state == IN_FRAME)) begin
        if (rx_sof) begin
          if (state == IN_FRAME) abort <= 1'b1;
          cnt       <= CNT_ONE;
          ovf       <= 1'b0;
          len_field <= '0;
          state     <= rx_eof ? IDLE : IN_FRAME;
        end else begin
          cnt <= cnt_inc;
          if (cnt == CNT_MAX) ovf <= 1'b1;
          if (cnt == CNT_ONE) len_field <= cap_field;
          if (rx_eof) state <= IDLE;
        end
        if (rx_eof) begin
          len_valid    <= 1'b1;
          frame_len    <= rep_len;
          too_short    <= rep_short;
          too_long     <= rep_long;
          len_mismatch <= rep_mism;
          frame_good   <= ~(rep_short | rep_long | rep_mism);
        end
      end
    end
  end

endmodule

// File: doc/rx_frame_len_check.md
Name: rx_frame_len_check

Overview:
- Receive-path stage that consumes the 64-bit word stream from the RX aligner and measures each frame's byte length.
- Maintains a word counter that starts at 1 on start-of-frame.
- Checks frame length against minimum and maximum bounds, and checks it against the 802.3 length/type field.
- Emits one registered status report per frame to the RX statistics and frame-accept logic.

Parameters:
- CNT_WIDTH, 11, width of the internal word counter; saturates at all-ones.
- MIN_LEN, 64, minimum legal frame length in bytes, including FCS.
- MAX_LEN, 1518, maximum legal frame length in bytes, including FCS.

Ports:
- clk  input  1  receive clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- rx_valid  input  1  the current word is valid; all other rx_* inputs are qualified by it.
- rx_sof  input  1  the current word is the first word of a frame.
- rx_eof  input  1  the current word is the last word of a frame.
- rx_eof_bytes  input  3  valid bytes in the last word; 0 means 8, 1..7 are literal.
- rx_data  input  64  frame data; byte 0 of the word is bits 7:0 (first on the wire).
- len_valid  output  1  one-cycle pulse; all report outputs below are valid in this cycle.
- frame_len  output  16  frame byte count, saturating at 16'hFFFF.
- too_short  output  1  frame_len < MIN_LEN.
- too_long  output  1  frame_len > MAX_LEN, or the word counter saturated.
- len_mismatch  output  1  length field is ≤1500 and inconsistent with frame_len.
- frame_good  output  1  none of too_short, too_long, len_mismatch is set.
- abort  output  1  one-cycle pulse: a frame was dropped because a new rx_sof arrived before its rx_eof.

Behaviour:
- Reset: every output goes to 0, the FSM goes to IDLE, the word counter goes to 1, and the captured length field goes to 0.
- FSM states: IDLE and IN_FRAME.
  - IDLE, rx_valid & rx_sof & !rx_eof: counter loads 1, go to IN_FRAME.
  - IDLE, rx_valid & rx_sof & rx_eof: single-word frame; report immediately (see Report below), stay in IDLE.
  - IDLE, words without rx_sof: ignored.
  - IN_FRAME, rx_valid & !rx_sof & !rx_eof: counter increments.
  - IN_FRAME, rx_valid & rx_eof: counter increments for the last word, frame is reported, go to IDLE.
  - IN_FRAME, rx_valid & rx_sof: the current frame is dropped with no report; abort pulses next cycle; counter reloads 1 and the FSM stays in IN_FRAME (or reports at once if rx_eof is also set).
  - rx_valid = 0: no state change and no count, in any state.
- Counter saturation: once the counter reaches all-ones it holds; a sticky overflow flag is set, cleared on the next sof.
- Length field capture: on the second word of a frame (the valid word with counter = 1 in IN_FRAME), latch len_field = {rx_data[39:32], rx_data[47:40]} (bytes 12 and 13). A one-word frame leaves len_field = 0.
- Length arithmetic, with W = final word count and B = (rx_eof_bytes == 0 ? 8 : rx_eof_bytes):
  - frame_len = (W − 1)·8 + B, computed 17 bits wide and saturated to 16 bits.
- Mismatch rule, applied only when len_field ≤ 1500:
  - len_field < 46: mismatch if frame_len ≠ 64.
  - otherwise: mismatch if frame_len − 18 ≠ len_field.
  - len_field > 1500 is a type field: len_mismatch = 0.
- Report: all report outputs are registered, with len_valid high exactly one cycle after the eof word is accepted. Report outputs other than len_valid and abort hold their values until the next report.
- Reset asserted mid-frame: the frame is discarded, no report and no abort.

Test Plan:
- 8 words, eof_bytes = 0, len_field 0x002E → frame_len = 64, frame_good = 1, len_valid exactly 1 cycle after the eof word.
- 8 words, eof_bytes = 4 → frame_len = 60, too_short = 1, frame_good = 0.
- 190 words, eof_bytes = 7, type 0x0800 → frame_len = 1519, too_long = 1. Same frame with eof_bytes = 6 → 1518, frame_good = 1.
- 13 words, eof_bytes = 4 (frame_len = 100):
  - len_field 0x0052 → len_mismatch = 0.
  - len_field 0x0040 → len_mismatch = 1.
  - len_field 0x0800 → len_mismatch = 0.
- Frame with rx_valid deasserted for 3 cycles mid-frame → length identical to the gap-free frame. rx_sof at word 5 of a frame → abort pulse, then only the second frame is reported.
- Reset pulsed at word 4 of a frame, followed by rx_eof → no len_valid. A one-word frame (sof & eof, eof_bytes = 0) → frame_len = 8, too_short = 1.
